// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: skid-register state encoding and per-stage NOP payloads.
package pipe_pkg;

    // Encoding doubles as the live-entry count, so occupancy is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam int          PIPE_NOP_W    = 96;
    localparam logic [95:0] PIPE_NOP_WORD = '0;

    function automatic logic [1:0] pipe_occupancy(input pipe_state_e st);
        return 2'(st);
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pipe_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register (head + skid) with registered ready/valid and a stall counter.
//   state    | meaning
//   ST_EMPTY | nothing held, out_data = NOP_WORD
//   ST_ONE   | head live
//   ST_FULL  | head and skid live, upstream stalled
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 96,
    parameter int                CNT_W    = 16,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(PIPE_NOP_WORD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              push, pop;

    // Handshake outputs come only from registered state: no in->out or out_ready->in_ready path.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = out_valid ? head_q : NOP_WORD;
    assign occupancy = pipe_occupancy(state_q);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            head_d  = NOP_WORD;
            skid_d  = NOP_WORD;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        head_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head_d = in_data;
                    end else if (push) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                        head_d  = NOP_WORD;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        head_d  = skid_q;
                        skid_d  = NOP_WORD;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    head_d  = NOP_WORD;
                    skid_d  = NOP_WORD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            head_q  <= NOP_WORD;
            skid_q  <= NOP_WORD;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    pipe_sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (out_valid && !out_ready && !flush),
        .cnt (stall_cnt)
    );

endmodule
